// File: rtl/register_bus_datapath.sv
// Register file and common-bus datapath: AR, PC, DR, AC, IR (and optional TR) around an 8-bit bus.
// Define RBD_TR_EN to implement TR; otherwise TR strobes are ignored and bus select 110 drives 0.
module register_bus_datapath #(
    parameter int unsigned         DATA_W   = 8,
    parameter logic [DATA_W-1:0]   AR_RESET = '0,
    parameter logic [DATA_W-1:0]   PC_RESET = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_AR,
    input  logic              load_PC,
    input  logic              load_DR,
    input  logic              load_AC,
    input  logic              load_IR,
    input  logic              load_TR,
    input  logic              clear_AR,
    input  logic              clear_PC,
    input  logic              clear_DR,
    input  logic              clear_AC,
    input  logic              clear_TR,
    input  logic              inc_AR,
    input  logic              inc_PC,
    input  logic              inc_DR,
    input  logic              inc_AC,
    input  logic              inc_TR,
    input  logic [2:0]        bus_selectors,
    input  logic              memory_write,
    input  logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] bus,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] AC,
    output logic [DATA_W-1:0] DR,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] AR,
    output logic              ac_zero
);

    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] tr_val;
    logic [DATA_W-1:0] ac_src;

    // Shared clear > load > inc > hold priority.
    function automatic logic [DATA_W-1:0] next_val(input logic clr, input logic ld,
                                                   input logic inc, input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] src);
        if (clr) begin
            return '0;
        end else if (ld) begin
            return src;
        end else if (inc) begin
            return cur + 1'b1;
        end
        return cur;
    endfunction

`ifdef RBD_TR_EN
    logic [DATA_W-1:0] tr_q, tr_d;

    always_comb begin
        tr_d = next_val(clear_TR, load_TR, inc_TR, tr_q, bus);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tr_q <= '0;
        end else begin
            tr_q <= tr_d;
        end
    end

    assign tr_val = tr_q;
`else
    logic unused_tr;
    assign unused_tr = ^{load_TR, clear_TR, inc_TR};
    assign tr_val    = '0;
`endif

    always_comb begin
        bus = '0;
        case (bus_selectors)
            3'b001:  bus = ar_q;
            3'b010:  bus = pc_q;
            3'b011:  bus = dr_q;
            3'b100:  bus = ac_q;
            3'b101:  bus = ir_q;
            3'b110:  bus = tr_val;
            3'b111:  bus = mem_rdata;
            default: bus = '0;
        endcase
    end

    assign ac_src = alu_enable ? alu_result : bus;

    always_comb begin
        ar_d = next_val(clear_AR, load_AR, inc_AR, ar_q, bus);
        pc_d = next_val(clear_PC, load_PC, inc_PC, pc_q, bus);
        dr_d = next_val(clear_DR, load_DR, inc_DR, dr_q, bus);
        ac_d = next_val(clear_AC, load_AC, inc_AC, ac_q, ac_src);
        ir_d = load_IR ? bus : ir_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ar_q <= AR_RESET;
            pc_q <= PC_RESET;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
        end
    end

    assign AR        = ar_q;
    assign PC        = pc_q;
    assign DR        = dr_q;
    assign AC        = ac_q;
    assign IR        = ir_q;
    assign ac_zero   = (ac_q == '0);
    assign mem_addr  = ar_q;
    assign mem_wdata = bus;
    assign mem_we    = memory_write;

endmodule

// File: tb/tb_register_bus_datapath.sv
// Directed, table-driven bench for register_bus_datapath plus hand sequences for store,
// TR configuration and mid-cycle reset.
module tb_register_bus_datapath;

    logic       clock;
    logic       reset_n;
    logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
    logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
    logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
    logic [2:0] bus_selectors;
    logic       memory_write;
    logic       alu_enable;
    logic [7:0] alu_result;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr, mem_wdata, bus, IR, AC, DR, PC, AR;
    logic       mem_we;
    logic       ac_zero;

    int errors = 0;
    int checks = 0;

    register_bus_datapath dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_AR      (load_AR),
        .load_PC      (load_PC),
        .load_DR      (load_DR),
        .load_AC      (load_AC),
        .load_IR      (load_IR),
        .load_TR      (load_TR),
        .clear_AR     (clear_AR),
        .clear_PC     (clear_PC),
        .clear_DR     (clear_DR),
        .clear_AC     (clear_AC),
        .clear_TR     (clear_TR),
        .inc_AR       (inc_AR),
        .inc_PC       (inc_PC),
        .inc_DR       (inc_DR),
        .inc_AC       (inc_AC),
        .inc_TR       (inc_TR),
        .bus_selectors(bus_selectors),
        .memory_write (memory_write),
        .alu_enable   (alu_enable),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .bus          (bus),
        .IR           (IR),
        .AC           (AC),
        .DR           (DR),
        .PC           (PC),
        .AR           (AR),
        .ac_zero      (ac_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ld = {AR,PC,DR,AC,IR,TR}; clr/inc = {AR,PC,DR,AC,TR}
    typedef struct {
        logic [5:0] ld;
        logic [4:0] clr;
        logic [4:0] inc;
        logic [2:0] sel;
        logic       alu_en;
        logic [7:0] alu_res;
        logic [7:0] rdata;
        logic [7:0] e_bus;
        logic [7:0] e_ar, e_pc, e_dr, e_ac, e_ir;
        logic       e_z;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic [5:0] ld, logic [4:0] clr, logic [4:0] inc,
                                logic [2:0] sel, logic alu_en, logic [7:0] alu_res,
                                logic [7:0] rdata, logic [7:0] e_bus, logic [7:0] e_ar,
                                logic [7:0] e_pc, logic [7:0] e_dr, logic [7:0] e_ac,
                                logic [7:0] e_ir, logic e_z);
        vec_t v;
        v.ld = ld; v.clr = clr; v.inc = inc; v.sel = sel;
        v.alu_en = alu_en; v.alu_res = alu_res; v.rdata = rdata; v.e_bus = e_bus;
        v.e_ar = e_ar; v.e_pc = e_pc; v.e_dr = e_dr; v.e_ac = e_ac; v.e_ir = e_ir;
        v.e_z = e_z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] ld, input logic [4:0] clr, input logic [4:0] inc,
                         input logic [2:0] sel, input logic alu_en, input logic [7:0] alu_res,
                         input logic [7:0] rdata);
        {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR} = ld;
        {clear_AR, clear_PC, clear_DR, clear_AC, clear_TR}     = clr;
        {inc_AR, inc_PC, inc_DR, inc_AC, inc_TR}               = inc;
        bus_selectors = sel;
        alu_enable    = alu_en;
        alu_result    = alu_res;
        mem_rdata     = rdata;
        memory_write  = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] ar, input logic [7:0] pc,
                              input logic [7:0] dr, input logic [7:0] ac, input logic [7:0] ir,
                              input logic z);
        chk({tag, " AR"}, AR, ar);
        chk({tag, " PC"}, PC, pc);
        chk({tag, " DR"}, DR, dr);
        chk({tag, " AC"}, AC, ac);
        chk({tag, " IR"}, IR, ir);
        chk({tag, " ac_zero"}, {7'd0, ac_zero}, {7'd0, z});
    endtask

    task automatic step(input logic [5:0] ld, input logic [2:0] sel, input logic [7:0] rdata);
        @(negedge clock);
        drive(ld, 5'b0, 5'b0, sel, 1'b0, 8'h00, rdata);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] prev_ar;
        string      tag;

        vecs[0]  = mk(6'b010000, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'h04, 8'h04,
                      8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1);
        vecs[1]  = mk(6'b000010, 5'b00000, 5'b01000, 3'b111, 0, 8'h00, 8'hA3, 8'hA3,
                      8'h00, 8'h05, 8'h00, 8'h00, 8'hA3, 1);
        vecs[2]  = mk(6'b100000, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'h55, 8'h55,
                      8'h55, 8'h05, 8'h00, 8'h00, 8'hA3, 1);
        vecs[3]  = mk(6'b010000, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'h10, 8'h10,
                      8'h55, 8'h10, 8'h00, 8'h00, 8'hA3, 1);
        vecs[4]  = mk(6'b010000, 5'b01000, 5'b01000, 3'b001, 0, 8'h00, 8'h00, 8'h55,
                      8'h55, 8'h00, 8'h00, 8'h00, 8'hA3, 1);
        vecs[5]  = mk(6'b010000, 5'b00000, 5'b01000, 3'b001, 0, 8'h00, 8'h00, 8'h55,
                      8'h55, 8'h55, 8'h00, 8'h00, 8'hA3, 1);
        vecs[6]  = mk(6'b000000, 5'b00000, 5'b01000, 3'b000, 0, 8'h00, 8'h00, 8'h00,
                      8'h55, 8'h56, 8'h00, 8'h00, 8'hA3, 1);
        vecs[7]  = mk(6'b100000, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'h99, 8'h99,
                      8'h99, 8'h56, 8'h00, 8'h00, 8'hA3, 1);
        vecs[8]  = mk(6'b000100, 5'b00000, 5'b00000, 3'b001, 1, 8'h3C, 8'h00, 8'h99,
                      8'h99, 8'h56, 8'h00, 8'h3C, 8'hA3, 0);
        vecs[9]  = mk(6'b000100, 5'b00000, 5'b00000, 3'b001, 0, 8'h3C, 8'h00, 8'h99,
                      8'h99, 8'h56, 8'h00, 8'h99, 8'hA3, 0);
        vecs[10] = mk(6'b000100, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'hFF, 8'hFF,
                      8'h99, 8'h56, 8'h00, 8'hFF, 8'hA3, 0);
        vecs[11] = mk(6'b000000, 5'b00000, 5'b00010, 3'b000, 0, 8'h00, 8'h00, 8'h00,
                      8'h99, 8'h56, 8'h00, 8'h00, 8'hA3, 1);
        vecs[12] = mk(6'b001000, 5'b00000, 5'b00000, 3'b111, 0, 8'h00, 8'h12, 8'h12,
                      8'h99, 8'h56, 8'h12, 8'h00, 8'hA3, 1);
        vecs[13] = mk(6'b001000, 5'b00000, 5'b00100, 3'b011, 0, 8'h00, 8'h00, 8'h12,
                      8'h99, 8'h56, 8'h12, 8'h00, 8'hA3, 1);
        vecs[14] = mk(6'b000000, 5'b00000, 5'b00100, 3'b011, 0, 8'h00, 8'h00, 8'h12,
                      8'h99, 8'h56, 8'h13, 8'h00, 8'hA3, 1);
        vecs[15] = mk(6'b000000, 5'b00100, 5'b00000, 3'b000, 0, 8'h00, 8'h00, 8'h00,
                      8'h99, 8'h56, 8'h00, 8'h00, 8'hA3, 1);
        vecs[16] = mk(6'b100000, 5'b00000, 5'b00000, 3'b101, 0, 8'h00, 8'h00, 8'hA3,
                      8'hA3, 8'h56, 8'h00, 8'h00, 8'hA3, 1);
        vecs[17] = mk(6'b001000, 5'b00000, 5'b00000, 3'b010, 0, 8'h00, 8'h00, 8'h56,
                      8'hA3, 8'h56, 8'h56, 8'h00, 8'hA3, 1);
        vecs[18] = mk(6'b000010, 5'b00000, 5'b00000, 3'b100, 0, 8'h00, 8'h00, 8'h00,
                      8'hA3, 8'h56, 8'h56, 8'h00, 8'h00, 1);
        vecs[19] = mk(6'b000000, 5'b10000, 5'b10000, 3'b001, 0, 8'h00, 8'h00, 8'hA3,
                      8'h00, 8'h56, 8'h56, 8'h00, 8'h00, 1);

        // Power-on reset
        reset_n = 1'b0;
        drive(6'b0, 5'b0, 5'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        #12;
        check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clock);
        reset_n = 1'b1;

        prev_ar = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tag = $sformatf("vec%0d", i);
            @(negedge clock);
            drive(vecs[i].ld, vecs[i].clr, vecs[i].inc, vecs[i].sel, vecs[i].alu_en,
                  vecs[i].alu_res, vecs[i].rdata);
            #1;
            chk({tag, " bus"}, bus, vecs[i].e_bus);
            chk({tag, " mem_wdata"}, mem_wdata, vecs[i].e_bus);
            chk({tag, " mem_addr"}, mem_addr, prev_ar);
            @(posedge clock);
            #1;
            check_regs(tag, vecs[i].e_ar, vecs[i].e_pc, vecs[i].e_dr, vecs[i].e_ac,
                       vecs[i].e_ir, vecs[i].e_z);
            prev_ar = vecs[i].e_ar;
        end

        // Store: AR=20, AC=7E, bus=AC with memory_write
        step(6'b100000, 3'b111, 8'h20);
        step(6'b000100, 3'b111, 8'h7E);
        @(negedge clock);
        drive(6'b0, 5'b0, 5'b0, 3'b100, 1'b0, 8'h00, 8'h00);
        memory_write = 1'b1;
        #1;
        chk("store mem_addr", mem_addr, 8'h20);
        chk("store mem_wdata", mem_wdata, 8'h7E);
        chk("store mem_we", {7'd0, mem_we}, 8'h01);
        @(posedge clock);
        #1;
        check_regs("store hold", 8'h20, 8'h56, 8'h56, 8'h7E, 8'h00, 1'b0);

        // TR: load FF then read it back through select 110
        step(6'b000001, 3'b111, 8'hFF);
        @(negedge clock);
        drive(6'b0, 5'b0, 5'b0, 3'b110, 1'b0, 8'h00, 8'h00);
        #1;
`ifdef RBD_TR_EN
        chk("tr bus", bus, 8'hFF);
`else
        chk("tr bus", bus, 8'h00);
`endif

        // Mid-cycle reset with PC=37
        step(6'b010000, 3'b111, 8'h37);
        chk("pre-reset PC", PC, 8'h37);
        @(negedge clock);
        drive(6'b0, 5'b0, 5'b0, 3'b010, 1'b0, 8'h00, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        check_regs("async reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        chk("async reset bus", bus, 8'h00);
        @(negedge clock);
        drive(6'b010000, 5'b0, 5'b00010, 3'b111, 1'b0, 8'h00, 8'h37);
        @(posedge clock);
        #1;
        check_regs("reset held", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clock);
        drive(6'b0, 5'b0, 5'b0, 3'b000, 1'b0, 8'h00, 8'h00);
        #2;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_regs("idle hold", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bus_datapath.md
# register_bus_datapath

Register file and common-bus datapath that executes the per-cycle control word issued by the control unit. Holds AR, PC, DR, AC, IR and TR, drives the 8-bit common bus from the register picked by `bus_selectors`, and presents address and write data to memory. Feeds `IR` back to the control unit and `AC`/`DR` to the ALU, and captures the ALU result into AC.

## Interface
- `DATA_W`, 8: width of every register, the bus and the memory data.
- `AR_RESET`, 8'h00: reset value of AR.
- `PC_RESET`, 8'h00: reset value of PC.
- `clock` in 1: single clock; all registers update on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load_AR`, `load_PC`, `load_DR`, `load_AC`, `load_IR`, `load_TR` in 1 each: load the register from the source defined under Operation.
- `clear_AR`, `clear_PC`, `clear_DR`, `clear_AC`, `clear_TR` in 1 each: synchronous clear to 0.
- `inc_AR`, `inc_PC`, `inc_DR`, `inc_AC`, `inc_TR` in 1 each: increment by 1, modulo 2^DATA_W.
- `bus_selectors` in 3: common-bus source select.
- `memory_write` in 1: write strobe from the control unit; passed through.
- `alu_enable` in 1: AC loads from `alu_result` instead of the bus.
- `alu_result` in DATA_W: combinational ALU output.
- `mem_rdata` in DATA_W: memory read data, combinational from `mem_addr`.
- `mem_addr` out DATA_W: equals AR.
- `mem_wdata` out DATA_W: equals the bus.
- `mem_we` out 1: equals `memory_write`.
- `bus` out DATA_W: current common-bus value.
- `IR`, `AC`, `DR`, `PC`, `AR` out DATA_W: register contents.
- `ac_zero` out 1: AC == 0, combinational.

## Operation
- Bus mux (combinational):
  - 000 drives 0.
  - 001 AR; 010 PC; 011 DR; 100 AC; 101 IR; 110 TR.
  - 111 `mem_rdata`.
- Per-register priority on each edge: clear > load > inc > hold.
  - IR has no clear or inc; it only loads or holds.
- Load sources:
  - AR, PC, DR, IR and TR load from the bus.
  - AC loads from `alu_result` when `alu_enable`=1, otherwise from the bus.
- Bus and register reads are evaluated before the edge. A register that is both bus source and load target gets its own old value. A register that increments while driving the bus puts its pre-increment value on the bus that cycle.
- Any combination of registers may update in the same cycle, e.g. `load_IR` with `inc_PC` and bus=111 is the fetch step.
- Increment wraps: 8'hFF + 1 = 8'h00, with no carry out.
- `memory_read` is not an input. Memory is read continuously through `mem_addr`.

## Timing
- Reset (`reset_n`=0) is asynchronous and takes effect immediately:
  - AR = `AR_RESET`, PC = `PC_RESET`.
  - DR, AC, IR, TR = 0.
  - `ac_zero`=1.
  - `bus` follows the select inputs.
- Reset released mid-cycle: the first update occurs on the first rising edge with `reset_n`=1.
- Reset asserted mid-instruction: all register contents are discarded, with no partial update.
- Latency:
  - Register outputs change one edge after the control strobe.
  - `bus`, `mem_addr`, `mem_wdata`, `mem_we` and `ac_zero` are zero-latency combinational paths.
- `mem_we` is level-based. The memory samples `mem_addr`/`mem_wdata` on the same rising edge.

## Configuration
- `RBD_TR_EN` defined: TR is implemented and obeys load, clear and inc; bus select 110 drives TR.
- `RBD_TR_EN` undefined:
  - TR is not instantiated.
  - `load_TR`, `clear_TR` and `inc_TR` are ignored.
  - Bus select 110 drives 0.

## Test plan
- Reset and hold: assert `reset_n`=0 mid-cycle with PC=8'h37 -> PC=8'h00 immediately and `ac_zero`=1; release with all strobes low for 5 edges -> all registers unchanged.
- Fetch: PC=8'h04, `mem_rdata`=8'hA3, bus=111, `load_IR`=1, `inc_PC`=1 -> after one edge IR=8'hA3 and PC=8'h05.
- Priority: PC=8'h10, bus=001 with AR=8'h55, `clear_PC`=`load_PC`=`inc_PC`=1 -> PC=8'h00. Drop clear -> PC=8'h55. Only inc -> PC=8'h56.
- ALU path: `alu_result`=8'h3C, bus=001 with AR=8'h99, `load_AC`=1 -> with `alu_enable`=1 AC=8'h3C; with `alu_enable`=0 AC=8'h99.
- Wrap and self-source: AC=8'hFF, `inc_AC` -> AC=8'h00 and `ac_zero`=1. DR=8'h12, bus=011, `load_DR`+`inc_DR` -> DR=8'h12.
- Store and config: AC=8'h7E, AR=8'h20, bus=100, `memory_write`=1 -> `mem_addr`=8'h20, `mem_wdata`=8'h7E, `mem_we`=1. Without `RBD_TR_EN`, `load_TR` from bus 8'hFF followed by bus=110 -> bus=8'h00.
